// File: rtl/xf100_exu_wbck_arb.sv
// EXU write-back arbiter: one small FIFO per result source, drained by a
// round-robin pick into a registered regfile write port. Also publishes a
// bitmap of destination registers whose results are still in flight so
// decode can stall on RAW/WAW hazards.

// Per-channel result queue holding {rdidx, data}. Pointers carry an extra
// wrap bit so full/empty are told apart without a separate counter.
module xf100_exu_wbck_fifo #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int DEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [XLEN-1:0]           push_data,
  input  logic [RFIDX_W-1:0]        push_rdidx,
  output logic                      full,
  output logic                      empty,
  output logic [XLEN-1:0]           head_data,
  output logic [RFIDX_W-1:0]        head_rdidx,
  output logic [(1<<RFIDX_W)-1:0]   pend
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = RFIDX_W + XLEN;

  logic [AW:0]                 wr_ptr_q, wr_ptr_d;
  logic [AW:0]                 rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][EW-1:0]    mem_q, mem_d;
  logic [AW:0]                 cnt;
  logic [AW-1:0]               off;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign cnt   = wr_ptr_q - rd_ptr_q;
  assign {head_rdidx, head_data} = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers/storage; push and pop are independent, so a same-cycle
  // push+pop leaves the occupancy unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {push_rdidx, push_data};
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Destination bitmap of the occupied slots; x0 never counts as pending.
  always_comb begin
    pend = '0;
    off  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      off = AW'(k) - rd_ptr_q[AW-1:0];
      if ({1'b0, off} < cnt) pend[mem_q[k][EW-1 -: RFIDX_W]] = 1'b1;
    end
    pend[0] = 1'b0;
  end

  // Queue state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

module xf100_exu_wbck_arb #(
  parameter int NCH     = 2,
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCH-1:0]             wbck_i_valid,
  output logic [NCH-1:0]             wbck_i_ready,
  input  logic [NCH*XLEN-1:0]        wbck_i_data,
  input  logic [NCH*RFIDX_W-1:0]     wbck_i_rdidx,
  output logic                       wbck_o_wbck_en,
  output logic [XLEN-1:0]            wbck_o_wbck_data,
  output logic [RFIDX_W-1:0]         wbck_o_wbck_rdidx,
  output logic [$clog2(NCH):0]       wbck_o_ch,
  output logic [(1<<RFIDX_W)-1:0]    wbck_o_pend
);
  // rr needs at least one bit even when there is a single channel.
  localparam int RRW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CHW  = $clog2(NCH) + 1;
  localparam int NREG = 1 << RFIDX_W;

  logic [NCH-1:0]                full, empty, push, pop;
  logic [NCH-1:0][XLEN-1:0]      hd_data;
  logic [NCH-1:0][RFIDX_W-1:0]   hd_rdidx;
  logic [NCH-1:0][NREG-1:0]      ch_pend;

  logic [RRW-1:0]                rr_q, rr_d;
  logic [RRW-1:0]                cand, gnt_idx;
  logic                          gnt_vld;

  logic                          en_q, en_d;
  logic [XLEN-1:0]               data_q, data_d;
  logic [RFIDX_W-1:0]            rdidx_q, rdidx_d;
  logic [CHW-1:0]                ch_q, ch_d;

  // Ready is purely state-based: a full queue refuses even if it is
  // drained this very cycle.
  assign wbck_i_ready = ~full;
  assign push         = wbck_i_valid & ~full;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    xf100_exu_wbck_fifo #(
      .XLEN(XLEN), .RFIDX_W(RFIDX_W), .DEPTH(DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push[c]),
      .pop        (pop[c]),
      .push_data  (wbck_i_data[c*XLEN +: XLEN]),
      .push_rdidx (wbck_i_rdidx[c*RFIDX_W +: RFIDX_W]),
      .full       (full[c]),
      .empty      (empty[c]),
      .head_data  (hd_data[c]),
      .head_rdidx (hd_rdidx[c]),
      .pend       (ch_pend[c])
    );
  end

  // Round-robin pick: scan from rr upward, wrapping, first non-empty wins;
  // the winner's successor gets top priority next time.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    pop     = '0;
    rr_d    = rr_q;
    for (int i = 0; i < NCH; i++) begin
      cand = RRW'((int'(rr_q) + i) % NCH);
      if (!gnt_vld && !empty[cand]) begin
        gnt_vld   = 1'b1;
        gnt_idx   = cand;
        pop[cand] = 1'b1;
        rr_d      = RRW'((int'(cand) + 1) % NCH);
      end
    end
  end

  // Output stage: x0 results are consumed but never enable a write; with
  // no grant the payload holds and only the enable drops.
  always_comb begin
    en_d    = 1'b0;
    data_d  = data_q;
    rdidx_d = rdidx_q;
    ch_d    = ch_q;
    if (gnt_vld) begin
      en_d    = |hd_rdidx[gnt_idx];
      data_d  = hd_data[gnt_idx];
      rdidx_d = hd_rdidx[gnt_idx];
      ch_d    = CHW'(gnt_idx);
    end
  end

  // Pending bitmap: anything queued plus the write currently presented.
  always_comb begin
    wbck_o_pend = '0;
    for (int c = 0; c < NCH; c++) wbck_o_pend = wbck_o_pend | ch_pend[c];
    if (en_q) wbck_o_pend[rdidx_q] = 1'b1;
    wbck_o_pend[0] = 1'b0;
  end

  // Arbiter pointer and registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q    <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      rdidx_q <= '0;
      ch_q    <= '0;
    end else begin
      rr_q    <= rr_d;
      en_q    <= en_d;
      data_q  <= data_d;
      rdidx_q <= rdidx_d;
      ch_q    <= ch_d;
    end
  end

  assign wbck_o_wbck_en    = en_q;
  assign wbck_o_wbck_data  = data_q;
  assign wbck_o_wbck_rdidx = rdidx_q;
  assign wbck_o_ch         = ch_q;
endmodule

// File: tb/tb_xf100_exu_wbck_arb.sv
// Bench for the write-back arbiter: directed vector table, a reset-in-flight
// sequence, a backpressure/round-robin sequence and a randomized run checked
// against a queue-based reference model.
module tb_xf100_exu_wbck_arb;
  localparam int NCH = 2, XLEN = 32, RFIDX_W = 5, DEPTH = 2;
  localparam int CHW = 2, NREG = 32;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NCH-1:0]          vld = '0;
  logic [NCH-1:0]          rdy;
  logic [NCH*XLEN-1:0]     din = '0;
  logic [NCH*RFIDX_W-1:0]  rin = '0;
  logic                    en;
  logic [XLEN-1:0]         odata;
  logic [RFIDX_W-1:0]      ordx;
  logic [CHW-1:0]          och;
  logic [NREG-1:0]         pend;

  always #5 clk = ~clk;

  xf100_exu_wbck_arb #(.NCH(NCH), .XLEN(XLEN), .RFIDX_W(RFIDX_W), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .wbck_i_valid      (vld),
    .wbck_i_ready      (rdy),
    .wbck_i_data       (din),
    .wbck_i_rdidx      (rin),
    .wbck_o_wbck_en    (en),
    .wbck_o_wbck_data  (odata),
    .wbck_o_wbck_rdidx (ordx),
    .wbck_o_ch         (och),
    .wbck_o_pend       (pend)
  );

  // Reference model: one queue per channel plus the presented write.
  typedef struct { logic [RFIDX_W-1:0] rd; logic [XLEN-1:0] d; } ent_t;
  ent_t            mq [NCH][$];
  int              m_rr;
  logic            m_en;
  logic [4:0]      m_rd;
  logic [31:0]     m_d;
  int              m_ch;
  logic [NCH-1:0]  acc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    m_rr = 0; m_en = 1'b0; m_rd = '0; m_d = '0; m_ch = 0; acc = '0;
  endtask

  task automatic chk_model();
    logic [NREG-1:0] ep;
    logic [NCH-1:0]  er;
    ep = '0;
    er = '0;
    for (int c = 0; c < NCH; c++) begin
      er[c] = (mq[c].size() < DEPTH);
      for (int k = 0; k < mq[c].size(); k++)
        if (mq[c][k].rd != 0) ep[mq[c][k].rd] = 1'b1;
    end
    if (m_en) ep[m_rd] = 1'b1;
    chk("mdl_en",    en,    m_en);
    chk("mdl_rdidx", ordx,  m_rd);
    chk("mdl_data",  odata, m_d);
    chk("mdl_ch",    och,   m_ch);
    chk("mdl_ready", rdy,   er);
    chk("mdl_pend",  pend,  ep);
  endtask

  // Advance the model across one rising edge using pre-edge occupancy.
  task automatic upd();
    int   sz [NCH];
    ent_t e;
    bit   g;
    int   c;
    g = 1'b0;
    for (int i = 0; i < NCH; i++) sz[i] = mq[i].size();
    for (int i = 0; i < NCH; i++) begin
      c = (m_rr + i) % NCH;
      if (!g && sz[c] > 0) begin
        g = 1'b1;
        e = mq[c].pop_front();
        m_en = (e.rd != 0); m_rd = e.rd; m_d = e.d; m_ch = c;
        m_rr = (c + 1) % NCH;
      end
    end
    if (!g) m_en = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      acc[i] = vld[i] && (sz[i] < DEPTH);
      if (acc[i]) mq[i].push_back('{rd: rin[i*RFIDX_W +: RFIDX_W], d: din[i*XLEN +: XLEN]});
    end
  endtask

  // Called at posedge+1: check state-derived outputs, then take one edge.
  task automatic cyc();
    chk_model();
    @(posedge clk);
    upd();
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [4:0] r0, input logic [4:0] r1);
    vld = v; din = {d1, d0}; rin = {r1, r0};
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [31:0] d0, d1;
    logic [4:0]  r0, r1;
    logic        e_en;
    logic [4:0]  e_rd;
    logic [31:0] e_d;
    logic [1:0]  e_ch;
    logic [1:0]  e_rdy;
    logic [31:0] e_pend;
  } vec_t;
  vec_t tbl [12];

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] pushed0 [$];
    logic [31:0] wr0 [$];
    int          k0, k1, prev, pct;
    bit          saw_nrdy0;

    // Rows: inputs applied, then expectations of the state seen before the edge.
    tbl[0]  = '{2'b01, 32'hDEADBEEF, 32'h0,        5'd5, 5'd0, 1'b0, 5'd0, 32'h0,        2'd0, 2'b11, 32'h0};
    tbl[1]  = '{2'b00, 32'h0,        32'h0,        5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        2'd0, 2'b11, 32'h20};
    tbl[2]  = '{2'b10, 32'h0,        32'h11111111, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 2'd0, 2'b11, 32'h20};
    tbl[3]  = '{2'b10, 32'h0,        32'h77777777, 5'd0, 5'd7, 1'b0, 5'd5, 32'hDEADBEEF, 2'd0, 2'b11, 32'h0};
    tbl[4]  = '{2'b00, 32'h0,        32'h0,        5'd0, 5'd0, 1'b0, 5'd0, 32'h11111111, 2'd1, 2'b11, 32'h80};
    tbl[5]  = '{2'b11, 32'hA0A0A0A0, 32'hB0B0B0B0, 5'd3, 5'd4, 1'b1, 5'd7, 32'h77777777, 2'd1, 2'b11, 32'h80};
    tbl[6]  = '{2'b11, 32'hA1A1A1A1, 32'hB1B1B1B1, 5'd6, 5'd9, 1'b0, 5'd7, 32'h77777777, 2'd1, 2'b11, 32'h18};
    tbl[7]  = '{2'b00, 32'h0,        32'h0,        5'd0, 5'd0, 1'b1, 5'd3, 32'hA0A0A0A0, 2'd0, 2'b01, 32'h258};
    tbl[8]  = '{2'b00, 32'h0,        32'h0,        5'd0, 5'd0, 1'b1, 5'd4, 32'hB0B0B0B0, 2'd1, 2'b11, 32'h250};
    tbl[9]  = '{2'b00, 32'h0,        32'h0,        5'd0, 5'd0, 1'b1, 5'd6, 32'hA1A1A1A1, 2'd0, 2'b11, 32'h240};
    tbl[10] = '{2'b00, 32'h0,        32'h0,        5'd0, 5'd0, 1'b1, 5'd9, 32'hB1B1B1B1, 2'd1, 2'b11, 32'h200};
    tbl[11] = '{2'b00, 32'h0,        32'h0,        5'd0, 5'd0, 1'b0, 5'd9, 32'hB1B1B1B1, 2'd1, 2'b11, 32'h0};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", en, 1'b0);
    chk("rst_data", odata, 32'h0);
    chk("rst_rdidx", ordx, 5'd0);
    chk("rst_ch", och, 2'd0);
    chk("rst_ready", rdy, 2'b11);
    chk("rst_pend", pend, 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Directed table: single push latency, x0 drop, push+pop, round-robin.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].r0, tbl[i].r1);
      chk($sformatf("tbl%0d_en", i),    en,    tbl[i].e_en);
      chk($sformatf("tbl%0d_rdidx", i), ordx,  tbl[i].e_rd);
      chk($sformatf("tbl%0d_data", i),  odata, tbl[i].e_d);
      chk($sformatf("tbl%0d_ch", i),    och,   tbl[i].e_ch);
      chk($sformatf("tbl%0d_ready", i), rdy,   tbl[i].e_rdy);
      chk($sformatf("tbl%0d_pend", i),  pend,  tbl[i].e_pend);
      cyc();
    end

    // Reset with three entries queued and a write in flight.
    drive(2'b11, 32'h5A5A0001, 32'h5A5A0002, 5'd1, 5'd2);
    cyc();
    drive(2'b11, 32'h5A5A0003, 32'h5A5A0004, 5'd3, 5'd4);
    cyc();
    #2 rst = 1'b1;
    vld = '0;
    #1;
    chk("midrst_en", en, 1'b0);
    chk("midrst_pend", pend, 32'h0);
    chk("midrst_ready", rdy, 2'b11);
    @(posedge clk);
    #1;
    chk("midrst_en_next", en, 1'b0);
    @(negedge clk) rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_nostale", en, 1'b0);
      cyc();
    end

    // Both channels push every cycle: grants alternate and ch0 backs up.
    k0 = 0; k1 = 0; prev = -1; saw_nrdy0 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive(2'b11, 32'hC0000000 + k0, 32'hD1000000 + k1,
            5'(1 + (k0 % 15)), 5'(16 + (k1 % 15)));
      if (!rdy[0]) saw_nrdy0 = 1'b1;
      cyc();
      if (acc[0]) begin pushed0.push_back(din[31:0]); k0++; end
      if (acc[1]) k1++;
      if (en) begin
        if (och == 0) wr0.push_back(odata);
        if (prev >= 0) chk("rr_alt", och, 2'(prev ^ 1));
        prev = och;
      end
    end
    vld = '0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (en && och == 0) wr0.push_back(odata);
    end
    chk("bp_ready0_low", saw_nrdy0, 1'b1);
    chk("bp_count", wr0.size(), pushed0.size());
    for (int i = 0; i < wr0.size() && i < pushed0.size(); i++)
      chk("bp_order", wr0[i], pushed0[i]);

    // Randomized traffic against the model; offers held until accepted.
    for (int n = 0; n < 600; n++) begin
      pct = (n < 300) ? 40 : 85;
      for (int c = 0; c < NCH; c++) begin
        if (!vld[c] || acc[c]) begin
          vld[c] = ($urandom_range(0, 99) < pct);
          rin[c*RFIDX_W +: RFIDX_W] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          din[c*XLEN +: XLEN] = $urandom;
        end
      end
      cyc();
    end
    vld = '0;
    repeat (6) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
